// File: rtl/table_operand_seq.sv
// table_operand_seq
//   Operand sequencer for the init-table compute stage. Holds a DIM x DIM
//   table of WIDTH-bit words (reset-loaded to r*DIM+c). On START, it streams
//   every entry in row-major order as the pair A=tab[r][c] and B=tab[c][r]
//   over a valid/ready handshake. The table is host-writable only while idle.
// Ports
//   i_clk, i_rst_n   clock (rising edge), async active-low reset
//   i_we/i_waddr/i_wdata  table write ({row,col} address), idle only
//   i_start, i_abort      begin / terminate a sweep
//   o_a, o_b, o_valid, i_ready  operand stream (B is the transposed entry)
//   o_idx                 current {row,col}
//   o_busy, o_done        busy in RUN, one-cycle pulse after the last beat
//   o_werr                sticky: write attempted outside idle
module table_operand_seq #(
  parameter int WIDTH = 8,
  parameter int DIM   = 4,
  localparam int HW   = $clog2(DIM),
  localparam int AW   = 2*HW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_start,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [AW-1:0]    o_idx,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_werr
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_idx, w_idx_nxt;
  logic [WIDTH-1:0] r_tab [DIM*DIM];
  logic             r_werr;
  logic [AW-1:0]    w_tidx;

  // Next state / index. ABORT outranks a beat in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_state_nxt = S_RUN;
        w_idx_nxt   = '0;
      end
      S_RUN: begin
        if (i_abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else if (i_ready) begin
          // Index is exactly AW bits, so the last beat wraps it to 0.
          w_idx_nxt = r_idx + AW'(1);
          if (r_idx == {AW{1'b1}}) w_state_nxt = S_FIN;
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Table: flat row-major storage, so entry i holds r*DIM+c == i at reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DIM*DIM; i++) r_tab[i] <= WIDTH'(i);
    end else if (i_we && r_state == S_IDLE) begin
      r_tab[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                       r_werr <= 1'b0;
    else if (i_we && r_state != S_IDLE) r_werr <= 1'b1;
  end

  // Transpose address: swap the row and col halves of {r,c}.
  assign w_tidx  = {r_idx[HW-1:0], r_idx[AW-1:HW]};

  assign o_a     = r_tab[r_idx];
  assign o_b     = r_tab[w_tidx];
  assign o_idx   = r_idx;
  assign o_valid = (r_state == S_RUN);
  assign o_busy  = (r_state == S_RUN);
  assign o_done  = (r_state == S_FIN);
  assign o_werr  = r_werr;

endmodule

// File: tb/tb_table_operand_seq.sv
module tb_table_operand_seq;
  localparam int WIDTH = 8;
  localparam int DIM   = 4;
  localparam int N     = DIM*DIM;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             we = 1'b0;
  logic [3:0]       waddr = '0;
  logic [WIDTH-1:0] wdata = '0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] a, b;
  logic             valid, busy, done, werr;
  logic [3:0]       idx;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle, 1 streaming, 2 finishing pulse.
  int m_tab [N];
  int m_mode;
  int m_k;
  int m_werr;
  int m_beats;

  table_operand_seq #(.WIDTH(WIDTH), .DIM(DIM)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_we(we), .i_waddr(waddr),
    .i_wdata(wdata), .i_start(start), .i_abort(abort),
    .o_a(a), .o_b(b), .o_valid(valid), .i_ready(ready),
    .o_idx(idx), .o_busy(busy), .o_done(done), .o_werr(werr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tr(input int k);
    return (k % DIM) * DIM + k / DIM;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_tab[i] = i % (1 << WIDTH);
    m_mode = 0; m_k = 0; m_werr = 0; m_beats = 0;
  endtask

  task automatic check_outs();
    chk("valid", int'(valid), int'(m_mode == 1));
    chk("busy",  int'(busy),  int'(m_mode == 1));
    chk("done",  int'(done),  int'(m_mode == 2));
    chk("idx",   int'(idx),   m_k);
    chk("a",     int'(a),     m_tab[m_k]);
    chk("b",     int'(b),     m_tab[tr(m_k)]);
    chk("werr",  int'(werr),  m_werr);
  endtask

  // One cycle: check outputs at negedge, apply inputs, advance the model
  // across the rising edge, return at the next negedge.
  task automatic cyc(input bit i_we, input int i_wa, input int i_wd,
                     input bit i_st, input bit i_ab, input bit i_rd);
    check_outs();
    we = i_we; waddr = 4'(i_wa); wdata = WIDTH'(i_wd);
    start = i_st; abort = i_ab; ready = i_rd;
    case (m_mode)
      0: begin
        if (i_we) m_tab[i_wa] = i_wd;
        if (i_st) begin m_mode = 1; m_k = 0; m_beats = 0; end
      end
      1: begin
        if (i_we) m_werr = 1;
        if (i_ab) begin m_mode = 0; m_k = 0; end
        else if (i_rd) begin
          m_beats++;
          if (m_k == N-1) begin
            m_mode = 2; m_k = 0;
            chk("beats_per_sweep", m_beats, N);
          end else m_k++;
        end
      end
      default: begin
        if (i_we) m_werr = 1;
        m_mode = 0;
      end
    endcase
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must return immediately.
  task automatic async_reset();
    #2 rst_n = 1'b0;
    we = 0; start = 0; abort = 0; ready = 0;
    model_reset();
    #1;
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic sweep_ready_high();
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < N + 2; i++) cyc(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Default table sweep with READY held high; DONE follows the last beat.
    sweep_ready_high();
    chk("default_beat6_a", 6, m_tab[6]);

    // Write {1,2}=200 then sweep.
    cyc(1, 6, 200, 0, 0, 0);
    sweep_ready_high();

    // READY toggling 1,0,0,...
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3*N + 4; i++) cyc(0, 0, 0, 0, 0, (i % 3) == 0);

    // Abort at IDX=5 with READY=1, then restart.
    cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Write during run -> sticky WERR, table untouched.
    cyc(1, 0, 99, 0, 0, 1);
    for (int i = 0; i < N + 3; i++) cyc(0, 0, 0, 0, 0, 1);
    sweep_ready_high();

    // Reset mid-sweep after a prior write of 200.
    async_reset();
    cyc(1, 6, 200, 1, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1);
    async_reset();
    sweep_ready_high();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) async_reset();
      else cyc($urandom_range(0, 5) == 0, $urandom_range(0, N-1),
               $urandom_range(0, 255), $urandom_range(0, 7) == 0,
               $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);
    end
    check_outs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
